// File: rtl/tm_clause_bank_if.sv
// -----------------------------------------------------------------------------
// tm_clause_bank_if
// Handshake bundle for the Tsetlin-machine clause bank.
//   in_valid / in_ready     : input vector + command handshake
//   in_features             : boolean feature vector
//   in_train                : 1 = evaluate then update, 0 = inference only
//   in_fb_type              : 0 = Type I feedback, 1 = Type II feedback
//   in_fb_mask              : per-clause feedback enable
//   out_valid / out_ready   : result handshake
//   out_clauses             : inference clause outputs
//   out_score               : signed polarity vote
// master = producer of inputs / consumer of results, slave = clause bank.
// -----------------------------------------------------------------------------
interface tm_clause_bank_if #(
    parameter int N_FEATURES = 2,
    parameter int N_CLAUSES  = 4,
    parameter int SCORE_W    = $clog2(N_CLAUSES) + 1
);
    logic                        in_valid;
    logic                        in_ready;
    logic [N_FEATURES-1:0]       in_features;
    logic                        in_train;
    logic                        in_fb_type;
    logic [N_CLAUSES-1:0]        in_fb_mask;
    logic                        out_valid;
    logic                        out_ready;
    logic [N_CLAUSES-1:0]        out_clauses;
    logic signed [SCORE_W-1:0]   out_score;

    modport master (
        output in_valid, in_features, in_train, in_fb_type, in_fb_mask, out_ready,
        input  in_ready, out_valid, out_clauses, out_score
    );

    modport slave (
        input  in_valid, in_features, in_train, in_fb_type, in_fb_mask, out_ready,
        output in_ready, out_valid, out_clauses, out_score
    );
endinterface

// File: rtl/tm_clause_bank.sv
// -----------------------------------------------------------------------------
// tm_clause_bank
// Trainable Tsetlin-machine clause bank. Holds one TA counter per literal per
// clause; the counter MSB is the include decision. Per accepted input it
// evaluates all clauses (one EVAL cycle), optionally walks the clauses one per
// cycle applying Type I / Type II feedback to the masked ones (UPDATE), then
// presents the result until accepted (DONE).
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   bus (slave)   : input command handshake and result handshake
//   ta_rd_clause  : debug readback clause index
//   ta_rd_lit     : debug readback literal index
//   ta_rd_state   : combinational TA counter at the addressed clause/literal
// -----------------------------------------------------------------------------
module tm_clause_bank #(
    parameter  int N_FEATURES = 2,
    parameter  int N_CLAUSES  = 4,
    parameter  int STATE_BITS = 4,
    parameter  int SCORE_W    = $clog2(N_CLAUSES) + 1,
    localparam int L          = 2 * N_FEATURES,
    localparam int CW         = $clog2(N_CLAUSES),
    localparam int LW         = $clog2(L)
) (
    input  logic                  clk,
    input  logic                  rst,
    tm_clause_bank_if.slave       bus,
    input  logic [CW-1:0]         ta_rd_clause,
    input  logic [LW-1:0]         ta_rd_lit,
    output logic [STATE_BITS-1:0] ta_rd_state
);

    localparam logic [STATE_BITS-1:0] STATE_MAX   = {STATE_BITS{1'b1}};
    localparam logic [STATE_BITS-1:0] STATE_RESET = STATE_BITS'((1 << (STATE_BITS - 1)) - 1);
    localparam logic [CW-1:0]         LAST_CLAUSE = CW'(N_CLAUSES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_EVAL,
        S_UPDATE,
        S_DONE
    } state_t;

    state_t state_reg, state_next;
    logic [CW-1:0] k_reg, k_next;

    // Command captured at the input handshake
    logic [N_FEATURES-1:0] features_reg;
    logic                  train_reg;
    logic                  fb_type_reg;
    logic [N_CLAUSES-1:0]  mask_reg;

    // Results registered in EVAL
    logic [N_CLAUSES-1:0]        out_clauses_reg;
    logic signed [SCORE_W-1:0]   out_score_reg;
    logic [N_CLAUSES-1:0]        trn_clause_reg;

    logic [STATE_BITS-1:0] ta_reg [N_CLAUSES][L];

    logic [L-1:0]                   literals;
    logic [N_CLAUSES-1:0][L-1:0]    include_vec;
    logic [N_CLAUSES-1:0]           clause_inf;
    logic [N_CLAUSES-1:0]           clause_trn;
    logic signed [SCORE_W-1:0]      score_next;

    // Literal i < N_FEATURES is the negated feature, the rest are the plain ones.
    assign literals = {features_reg, ~features_reg};

    // ------------------------------------------------------------------
    // Clause evaluation from the current TA state
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < N_CLAUSES; gi++) begin : g_eval
            for (genvar li = 0; li < L; li++) begin : g_inc
                assign include_vec[gi][li] = ta_reg[gi][li][STATE_BITS-1];
            end
            // Every included literal must be true; excluded ones are don't-care.
            // Training treats an empty clause as 1, inference as 0.
            assign clause_trn[gi] = &(~include_vec[gi] | literals);
            assign clause_inf[gi] = clause_trn[gi] & (|include_vec[gi]);
        end
    endgenerate

    always_comb begin
        score_next = '0;
        for (int j = 0; j < N_CLAUSES; j++) begin
            if (clause_inf[j]) begin
                if ((j % 2) == 0) begin
                    score_next = score_next + SCORE_W'(1);
                end else begin
                    score_next = score_next - SCORE_W'(1);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= S_IDLE;
            k_reg     <= '0;
        end else begin
            state_reg <= state_next;
            k_reg     <= k_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        k_next     = k_reg;
        case (state_reg)
            S_IDLE: begin
                if (bus.in_valid) begin
                    state_next = S_EVAL;
                end
            end
            S_EVAL: begin
                k_next     = '0;
                state_next = train_reg ? S_UPDATE : S_DONE;
            end
            S_UPDATE: begin
                if (k_reg == LAST_CLAUSE) begin
                    state_next = S_DONE;
                end else begin
                    k_next = k_reg + CW'(1);
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    assign bus.in_ready    = (state_reg == S_IDLE);
    assign bus.out_valid   = (state_reg == S_DONE);
    assign bus.out_clauses = out_clauses_reg;
    assign bus.out_score   = out_score_reg;

    // ------------------------------------------------------------------
    // Command capture and result registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            features_reg    <= '0;
            train_reg       <= 1'b0;
            fb_type_reg     <= 1'b0;
            mask_reg        <= '0;
            out_clauses_reg <= '0;
            out_score_reg   <= '0;
            trn_clause_reg  <= '0;
        end else begin
            if (state_reg == S_IDLE && bus.in_valid) begin
                features_reg <= bus.in_features;
                train_reg    <= bus.in_train;
                fb_type_reg  <= bus.in_fb_type;
                mask_reg     <= bus.in_fb_mask;
            end
            if (state_reg == S_EVAL) begin
                out_clauses_reg <= clause_inf;
                out_score_reg   <= score_next;
                // Feedback uses these pre-update values for the whole walk.
                trn_clause_reg  <= clause_trn;
            end
        end
    end

    // ------------------------------------------------------------------
    // TA counters: clause k is updated in UPDATE cycle k when masked in
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < N_CLAUSES; gi++) begin : g_ta
            logic upd_en;
            assign upd_en = (state_reg == S_UPDATE) && (k_reg == CW'(gi)) && mask_reg[gi];

            for (genvar li = 0; li < L; li++) begin : g_lit
                logic                  inc, dec;
                logic [STATE_BITS-1:0] ta_next;

                always_comb begin
                    inc = 1'b0;
                    dec = 1'b0;
                    if (!fb_type_reg) begin
                        // Type I: reinforce true literals of firing clauses,
                        // forget everything else.
                        if (trn_clause_reg[gi] && literals[li]) begin
                            inc = 1'b1;
                        end else begin
                            dec = 1'b1;
                        end
                    end else begin
                        // Type II: push excluded false literals toward include
                        // so the firing clause is broken next time.
                        inc = trn_clause_reg[gi] && !literals[li] && !include_vec[gi][li];
                    end

                    ta_next = ta_reg[gi][li];
                    if (inc && ta_reg[gi][li] != STATE_MAX) begin
                        ta_next = ta_reg[gi][li] + STATE_BITS'(1);
                    end else if (dec && ta_reg[gi][li] != '0) begin
                        ta_next = ta_reg[gi][li] - STATE_BITS'(1);
                    end
                end

                always_ff @(posedge clk) begin
                    if (rst) begin
                        ta_reg[gi][li] <= STATE_RESET;
                    end else if (upd_en) begin
                        ta_reg[gi][li] <= ta_next;
                    end
                end
            end
        end
    endgenerate

    assign ta_rd_state = ta_reg[ta_rd_clause][ta_rd_lit];

endmodule

// File: tb/tb_tm_clause_bank.sv
module tb_tm_clause_bank;
    localparam int NF = 2;
    localparam int NC = 4;
    localparam int SB = 4;
    localparam int SW = 3;
    localparam int L  = 2 * NF;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    tm_clause_bank_if #(.N_FEATURES(NF), .N_CLAUSES(NC), .SCORE_W(SW)) bus ();

    logic [1:0] ta_rd_clause;
    logic [1:0] ta_rd_lit;
    logic [3:0] ta_rd_state;

    tm_clause_bank #(
        .N_FEATURES(NF),
        .N_CLAUSES (NC),
        .STATE_BITS(SB),
        .SCORE_W   (SW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus.slave),
        .ta_rd_clause(ta_rd_clause),
        .ta_rd_lit   (ta_rd_lit),
        .ta_rd_state (ta_rd_state)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [NC-1:0] cl;
        logic [SW-1:0] sc;
    } exp_t;
    exp_t sb_q[$];

    int m_ta [NC][L];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic bit m_lit(input logic [NF-1:0] f, input int i);
        if (i < NF) return ~f[i];
        return f[i-NF];
    endfunction

    function automatic bit m_clause(input logic [NF-1:0] f, input int j, input bit trn);
        bit any = 1'b0;
        bit all = 1'b1;
        for (int i = 0; i < L; i++) begin
            if (m_ta[j][i] >= (1 << (SB - 1))) begin
                any = 1'b1;
                if (!m_lit(f, i)) all = 1'b0;
            end
        end
        return trn ? all : (all && any);
    endfunction

    task automatic m_reset();
        for (int j = 0; j < NC; j++)
            for (int i = 0; i < L; i++)
                m_ta[j][i] = (1 << (SB - 1)) - 1;
    endtask

    task automatic m_train(input logic [NF-1:0] f, input bit fbt, input logic [NC-1:0] m);
        bit c [NC];
        for (int j = 0; j < NC; j++) c[j] = m_clause(f, j, 1'b1);
        for (int j = 0; j < NC; j++) begin
            if (m[j]) begin
                for (int i = 0; i < L; i++) begin
                    bit lit = m_lit(f, i);
                    bit excl = (m_ta[j][i] < (1 << (SB - 1)));
                    if (!fbt) begin
                        if (c[j] && lit) m_ta[j][i] = (m_ta[j][i] < (1 << SB) - 1) ? m_ta[j][i] + 1 : m_ta[j][i];
                        else             m_ta[j][i] = (m_ta[j][i] > 0) ? m_ta[j][i] - 1 : 0;
                    end else if (c[j] && !lit && excl) begin
                        m_ta[j][i] = (m_ta[j][i] < (1 << SB) - 1) ? m_ta[j][i] + 1 : m_ta[j][i];
                    end
                end
            end
        end
    endtask

    // ---------------- DUT access tasks ----------------
    task automatic chk_ta(input string tag, input int c, input int l, input int exp);
        ta_rd_clause = 2'(c);
        ta_rd_lit    = 2'(l);
        #1;
        chk(tag, 32'(ta_rd_state), 32'(exp));
    endtask

    task automatic check_all_ta(input string tag);
        for (int c = 0; c < NC; c++)
            for (int l = 0; l < L; l++)
                chk_ta(tag, c, l, m_ta[c][l]);
    endtask

    task automatic drive_hs(input logic [NF-1:0] f, input bit t, input bit fbt, input logic [NC-1:0] m);
        int n = 0;
        @(negedge clk);
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("in_ready_wait", 32'(bus.in_ready), 32'd1);
        bus.in_valid    = 1'b1;
        bus.in_features = f;
        bus.in_train    = t;
        bus.in_fb_type  = fbt;
        bus.in_fb_mask  = m;
        @(posedge clk);
        #1;
        bus.in_valid    = 1'b0;
        bus.in_features = ~f;   // must not matter once captured
        bus.in_fb_mask  = ~m;
        bus.in_fb_type  = ~fbt;
    endtask

    task automatic xact(input logic [NF-1:0] f, input bit t, input bit fbt,
                        input logic [NC-1:0] m, input int hold);
        exp_t e;
        int   sc = 0;
        int   n  = 0;
        logic [NC+SW:0] snap;
        e.cl = '0;
        for (int j = 0; j < NC; j++) begin
            e.cl[j] = m_clause(f, j, 1'b0);
            if (e.cl[j]) sc += ((j % 2) == 0) ? 1 : -1;
        end
        e.sc = SW'(sc);
        sb_q.push_back(e);
        if (t) m_train(f, fbt, m);

        drive_hs(f, t, fbt, m);
        do begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end while (!bus.out_valid && n < 50);
        chk("latency", 32'(n), t ? 32'(NC + 1) : 32'd1);
        chk("in_ready_busy", 32'(bus.in_ready), 32'd0);

        snap = {bus.out_valid, bus.out_clauses, bus.out_score};
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk("hold_stable", 32'({bus.out_valid, bus.out_clauses, bus.out_score}), 32'(snap));
        end

        bus.out_ready = 1'b1;
        e = sb_q.pop_front();
        $display("xact f=%b train=%0d fbt=%0d mask=%b -> clauses=%b score=%0d (exp %b/%0d)",
                 f, t, fbt, m, bus.out_clauses, $signed(bus.out_score), e.cl, $signed(e.sc));
        chk("clauses", 32'(bus.out_clauses), 32'(e.cl));
        chk("score", 32'({1'b0, bus.out_score}), 32'({1'b0, e.sc}));
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        @(negedge clk);
        chk("out_valid_drop", 32'(bus.out_valid), 32'd0);
        chk("in_ready_back", 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst             = 1'b1;
        bus.in_valid    = 1'b0;
        bus.in_features = '0;
        bus.in_train    = 1'b0;
        bus.in_fb_type  = 1'b0;
        bus.in_fb_mask  = '0;
        bus.out_ready   = 1'b0;
        ta_rd_clause    = '0;
        ta_rd_lit       = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        m_reset();

        // reset state
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_clauses", 32'(bus.out_clauses), 32'd0);
        chk("rst_score", 32'({1'b0, bus.out_score}), 32'd0);
        for (int c = 0; c < NC; c++)
            for (int l = 0; l < L; l++)
                chk_ta("rst_ta", c, l, 7);

        // post-reset inference
        xact(2'b01, 1'b0, 1'b0, 4'b0000, 0);

        // Type I on clause 0
        xact(2'b01, 1'b1, 1'b0, 4'b0001, 0);
        chk_ta("t1_c0_l0", 0, 0, 6);
        chk_ta("t1_c0_l1", 0, 1, 8);
        chk_ta("t1_c0_l2", 0, 2, 8);
        chk_ta("t1_c0_l3", 0, 3, 6);
        chk_ta("t1_c1_l1", 1, 1, 7);
        check_all_ta("t1_model");

        xact(2'b01, 1'b0, 1'b0, 4'b0000, 0);
        xact(2'b10, 1'b0, 1'b0, 4'b0000, 0);

        // Type I on clause 1, then Type II that must leave clause 1 untouched
        xact(2'b01, 1'b1, 1'b0, 4'b0010, 0);
        xact(2'b10, 1'b1, 1'b1, 4'b0010, 0);
        chk_ta("t2_c1_l1", 1, 1, 8);
        chk_ta("t2_c1_l0", 1, 0, 6);
        // backpressure while presenting 0011 / 0
        xact(2'b01, 1'b0, 1'b0, 4'b0000, 5);

        // Type II on empty clause 2 includes its false literals
        xact(2'b10, 1'b1, 1'b1, 4'b0100, 0);
        chk_ta("t2_c2_l1", 2, 1, 8);
        chk_ta("t2_c2_l0", 2, 0, 7);
        check_all_ta("t2_model");
        xact(2'b01, 1'b0, 1'b0, 4'b0000, 0);
        xact(2'b10, 1'b0, 1'b0, 4'b0000, 0);

        // saturation
        for (int r = 0; r < 12; r++) xact(2'b01, 1'b1, 1'b0, 4'b0001, 0);
        chk_ta("sat_c0_l0", 0, 0, 0);
        chk_ta("sat_c0_l1", 0, 1, 15);
        chk_ta("sat_c0_l2", 0, 2, 15);
        chk_ta("sat_c0_l3", 0, 3, 0);
        check_all_ta("sat_model");

        // reset during UPDATE clause 2
        drive_hs(2'b01, 1'b1, 1'b0, 4'b0111);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        m_reset();
        chk("abort_out_valid", 32'(bus.out_valid), 32'd0);
        chk("abort_in_ready", 32'(bus.in_ready), 32'd1);
        chk("abort_clauses", 32'(bus.out_clauses), 32'd0);
        check_all_ta("abort_ta");
        repeat (3) begin
            @(negedge clk);
            chk("abort_no_output", 32'(bus.out_valid), 32'd0);
        end

        xact(2'b01, 1'b0, 1'b0, 4'b0000, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
